ntt_engine: RTL and testbench
=============================

NTT_ENGINE -- requirements
Module: ntt_engine

Interface
REQ-001 Parameter LOG_N, default 8: log2 of coefficient count N (N = 2^LOG_N).
REQ-002 Parameter COEFF_W, default 23: coefficient width in bits.
REQ-003 Parameter Q, default 8380417: prime modulus; Q < 2^COEFF_W.
REQ-004 Parameter NINV, default 8347681: N^-1 mod Q, used for inverse scaling.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin transform; sampled only in IDLE.
REQ-008 mode  input  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
REQ-009 in_valid / in_ready  input / output  1 / 1  coefficient load handshake.
REQ-010 in_data  input  COEFF_W  coefficient, natural order index 0..N-1.
REQ-011 out_valid / out_ready  output / input  1 / 1  result store handshake.
REQ-012 out_data  output  COEFF_W  result coefficient, index 0..N-1.
REQ-013 zeta_addr  output  LOG_N  twiddle ROM address.
REQ-014 zeta_data  input  COEFF_W  twiddle value for zeta_addr, valid in the same cycle (combinational ROM).
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse in the cycle after the final store beat.

Function
REQ-017 States: IDLE, LOAD, BFLY, SCALE, STORE. Transitions: IDLE->LOAD on start; LOAD->BFLY after beat N; BFLY->SCALE (mode=1) or BFLY->STORE (mode=0) after the last butterfly; SCALE->STORE after N cycles; STORE->IDLE after beat N.
REQ-018 LOAD: in_ready=1; each in_valid&in_ready beat writes (in_data mod Q) to buf[cnt] and increments cnt.
REQ-019 BFLY forward: len = N/2 down to 1; start steps by 2*len; k pre-increments from 0 (first twiddle at address 1); per j: t = zeta*buf[j+len] mod Q; buf[j+len] = (buf[j]-t) mod Q; buf[j] = (buf[j]+t) mod Q.
REQ-020 BFLY inverse: len = 1 up to N/2; k pre-decrements from N; z = Q - zeta_data; per j: u = buf[j]; buf[j] = (u+buf[j+len]) mod Q; buf[j+len] = z*(u-buf[j+len]) mod Q.
REQ-021 One butterfly per cycle, no bubbles between groups or stages; BFLY lasts exactly (N/2)*LOG_N cycles (1024 at defaults).
REQ-022 SCALE: buf[i] = buf[i]*NINV mod Q, one coefficient per cycle, i = 0..N-1.
REQ-023 STORE: out_valid=1, out_data=buf[cnt]; cnt advances only on out_valid&out_ready; out_data remains stable while out_ready=0.
REQ-024 Every result is fully reduced to [0, Q-1]; products use a 2*COEFF_W-bit intermediate.
REQ-025 start outside IDLE is ignored; in_valid outside LOAD is ignored (in_ready=0).
REQ-026 mode is latched at start; changes during a transform have no effect.
REQ-027 zeta_addr = 0 outside BFLY.

Reset
REQ-028 rst asserted: state=IDLE; in_ready, out_valid, busy, done = 0; out_data, zeta_addr, counters = 0; buf contents are not cleared.
REQ-029 Reset mid-transform aborts without a done pulse; the first cycle after rst deasserts is IDLE and accepts start.

Configuration
REQ-030 Macro NTT_INVERSE_EN: when defined, inverse butterflies and SCALE are built and mode selects the direction.
REQ-031 Without NTT_INVERSE_EN: mode is ignored, every transform is forward, SCALE is never entered, and the NINV multiplier is absent.

Verification
REQ-032 Forward, buf = {1,0,...,0}, out_ready=1 -> 256 outputs all equal 1; done one cycle after beat 256.
REQ-033 Load coefficient 0 = 8380417 (=Q), rest 0, forward -> all 256 outputs 0 (input reduction).
REQ-034 NTT_INVERSE_EN: random vector forward, outputs fed back inverse -> original vector exactly; inverse of all-ones -> {1,0,...,0}.
REQ-035 out_ready toggled every other cycle during STORE -> 256 beats in index order, no duplicates or drops, out_data stable while stalled.
REQ-036 rst pulsed at BFLY cycle 500 -> busy=0 next cycle, no done pulse; new start completes a correct forward transform.
REQ-037 start pulsed during LOAD and during BFLY -> ignored; exactly one done per accepted start; BFLY measured at 1024 cycles.

Source files
------------

// File: rtl/ntt_engine.sv
// ntt_engine: iterative in-place NTT/INTT over Z_Q with streaming load/store, one butterfly per cycle
// Ports: clk, rst (async, active-high); start/mode begin a transform (mode 1 = inverse);
//   in_valid/in_ready/in_data load N coefficients; out_valid/out_ready/out_data stream N results;
//   zeta_addr/zeta_data talk to an external combinational twiddle ROM; busy outside IDLE; done pulses once per transform.
// Build option: define NTT_INVERSE_EN to build the inverse butterflies and the N^-1 scaling pass.
module ntt_engine #(
  parameter int LOG_N   = 8,
  parameter int COEFF_W = 23,
  parameter int Q       = 8380417,
  parameter int NINV    = 8347681
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_data,
  output logic [LOG_N-1:0]   zeta_addr,
  input  logic [COEFF_W-1:0] zeta_data,
  output logic               busy,
  output logic               done
);
  localparam int W = COEFF_W;
  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] HALF = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] ONE = LOG_N'(1);
  localparam logic [W-1:0] QW = W'(Q);
  localparam logic [W:0] QE = (W + 1)'(Q);
  localparam logic [2*W-1:0] Q2 = (2 * W)'(Q);

  typedef enum logic [2:0] {IDLE, LOAD, BFLY, SCALE, STORE} state_t;
  state_t state;

  logic [W-1:0] mem [N];
  logic [LOG_N-1:0] cnt, j, len, k, jl;
  logic [LOG_N:0] nxt;
  logic grp_end, stage_end, last_bfly, inv;
  logic [W-1:0] a, b, ma, mb, red, na, nb;
  logic [2*W-1:0] prod;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return W'((s >= QE) ? s - QE : s);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? x - y : W'({1'b0, x} + QE - {1'b0, y});
  endfunction

`ifndef NTT_INVERSE_EN
  logic unused_mode;
  assign unused_mode = mode;
  assign inv = 1'b0;
`endif

  // j walks the butterflies of a group; the step after a group's last butterfly skips the upper half
  assign jl = j + len;
  assign nxt = {1'b0, j} + {1'b0, len} + (LOG_N + 1)'(1);
  assign grp_end = (j & (len - ONE)) == (len - ONE);
  assign stage_end = grp_end & nxt[LOG_N];
  assign last_bfly = stage_end & (inv ? (len == HALF) : (len == ONE));

  assign zeta_addr = k;
  assign busy = state != IDLE;
  assign out_data = out_valid ? mem[cnt] : '0;

  // One shared modular multiplier: forward twiddle, inverse twiddle on the difference, or N^-1 scaling
  always_comb begin
    a = mem[j];
    b = mem[jl];
    ma = zeta_data;
    mb = b;
`ifdef NTT_INVERSE_EN
    if (state == SCALE) begin
      ma = mem[cnt];
      mb = W'(NINV);
    end else if (inv) begin
      ma = QW - zeta_data;
      mb = mod_sub(a, b);
    end
`endif
    prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
    red = W'(prod % Q2);
    na = inv ? mod_add(a, b) : mod_add(a, red);
    nb = inv ? red : mod_sub(a, red);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      j <= '0;
      len <= '0;
      k <= '0;
`ifdef NTT_INVERSE_EN
      inv <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          in_ready <= 1'b1;
`ifdef NTT_INVERSE_EN
          inv <= mode;
`endif
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + ONE;
          if (&cnt) begin
            state <= BFLY;
            in_ready <= 1'b0;
            j <= '0;
            len <= inv ? ONE : HALF;
            k <= inv ? '1 : ONE;
          end
        end
        BFLY: begin
          j <= grp_end ? nxt[LOG_N-1:0] : j + ONE;
          if (grp_end) k <= inv ? k - ONE : k + ONE;
          if (stage_end) len <= inv ? len << 1 : len >> 1;
          if (last_bfly) begin
            state <= inv ? SCALE : STORE;
            out_valid <= !inv;
            k <= '0;
            j <= '0;
            len <= '0;
          end
        end
        SCALE: begin
          cnt <= cnt + ONE;
          if (&cnt) begin
            state <= STORE;
            out_valid <= 1'b1;
          end
        end
        STORE: if (out_ready) begin
          cnt <= cnt + ONE;
          if (&cnt) begin
            state <= IDLE;
            out_valid <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficient storage is never reset, so it lives in its own reset-free block
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) mem[cnt] <= W'(in_data % QW);
    if (state == BFLY) begin
      mem[j] <= na;
      mem[jl] <= nb;
    end
    if (state == SCALE) mem[cnt] <= red;
  end
endmodule

// File: tb/tb_ntt_engine.sv
// tb_ntt_engine: directed self-checking bench for ntt_engine with a bench-side twiddle ROM and reference NTT
module tb_ntt_engine;
  localparam int Q = 8380417;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy, done;
  logic [22:0] in_data = '0, out_data, zeta_data;
  logic [7:0] zeta_addr;
  logic [22:0] rom [256];
  logic [22:0] vec_in [256];
  logic [22:0] got [256];
  logic [22:0] exp_v [256];
  logic [22:0] orig [256];
  int checks = 0, errors = 0;

  ntt_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .zeta_addr(zeta_addr), .zeta_data(zeta_data), .busy(busy), .done(done)
  );

  assign zeta_data = rom[zeta_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Twiddles are powers of the 512th root of unity 1753 in bit-reversed order
  task automatic build_rom();
    for (int k = 0; k < 256; k++) begin
      int e = 0;
      longint unsigned r = 1;
      for (int bt = 0; bt < 8; bt++) e |= ((k >> bt) & 1) << (7 - bt);
      for (int i = 0; i < e; i++) r = (r * 1753) % Q;
      rom[k] = 23'(r);
    end
  endtask

  task automatic ref_fwd();
    int k = 0;
    longint unsigned z, t, a, b;
    for (int len = 128; len >= 1; len /= 2)
      for (int st = 0; st < 256; st += 2 * len) begin
        k++;
        z = rom[k];
        for (int j = st; j < st + len; j++) begin
          a = exp_v[j];
          b = exp_v[j + len];
          t = (z * b) % Q;
          exp_v[j + len] = 23'((a + Q - t) % Q);
          exp_v[j] = 23'((a + t) % Q);
        end
      end
  endtask

  task automatic cmp(input string tag);
    for (int i = 0; i < 256; i++) chk(tag, got[i], exp_v[i]);
  endtask

  task automatic load_vec(input bit poke);
    int i = 0, g = 0;
    while (i < 256 && g < 1000) begin
      @(negedge clk);
      g++;
      start = poke && i == 5;
      in_valid = 1'b1;
      in_data = vec_in[i];
      if (in_ready) i++;
    end
    chk("load_beats", i, 256);
  endtask

  task automatic run(input logic m, input bit stall, input bit poke);
    int n = 0, g = 0, bc = 0, dn = 0;
    logic [22:0] held = '0;
    bit hv = 0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    load_vec(poke);
    while (n < 256 && g < 5000) begin
      @(negedge clk);
      g++;
      if (zeta_addr != 0) bc++;
      if (done) dn++;
      start = poke && bc == 10;
      in_valid = poke && bc == 20;
      in_data = 23'd1;
      if (hv) chk("stall_hold", out_data, held);
      hv = 0;
      out_ready = stall ? g[0] : 1'b1;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end else if (out_valid) begin
        held = out_data;
        hv = 1;
      end
    end
    chk("store_beats", n, 256);
    chk("bfly_cycles", bc, 1024);
    chk("early_done", dn, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_zeta", zeta_addr, 0);
  endtask

  initial begin
    int bc, g, dn;
    build_rom();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_zeta", zeta_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) vec_in[i] = (i == 0) ? 23'd1 : 23'd0;
    run(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) chk("delta_fwd", got[i], 1);

    vec_in[0] = 23'(Q);
    run(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) chk("q_reduce", got[i], 0);

    for (int i = 0; i < 256; i++) begin
      vec_in[i] = 23'($urandom);
      exp_v[i] = 23'(vec_in[i] % Q);
    end
    ref_fwd();
    run(1'b0, 1'b1, 1'b1);
    cmp("stall_fwd");

    for (int i = 0; i < 256; i++) vec_in[i] = 23'($urandom);
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    load_vec(1'b0);
    bc = 0;
    g = 0;
    while (bc < 500 && g < 3000) begin
      @(negedge clk);
      g++;
      in_valid = 1'b0;
      if (zeta_addr != 0) bc++;
    end
    chk("rst_reach", bc, 500);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_zeta", zeta_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    for (int i = 0; i < 256; i++) begin
      vec_in[i] = 23'($urandom_range(Q - 1));
      exp_v[i] = vec_in[i];
      orig[i] = vec_in[i];
    end
    ref_fwd();
    run(1'b0, 1'b0, 1'b0);
    cmp("post_rst_fwd");

`ifdef NTT_INVERSE_EN
    for (int i = 0; i < 256; i++) begin
      vec_in[i] = got[i];
      exp_v[i] = orig[i];
    end
    run(1'b1, 1'b0, 1'b0);
    cmp("roundtrip");
    for (int i = 0; i < 256; i++) begin
      vec_in[i] = 23'd1;
      exp_v[i] = (i == 0) ? 23'd1 : 23'd0;
    end
    run(1'b1, 1'b0, 1'b0);
    cmp("inv_ones");
`else
    for (int i = 0; i < 256; i++) begin
      vec_in[i] = 23'($urandom);
      exp_v[i] = 23'(vec_in[i] % Q);
    end
    ref_fwd();
    run(1'b1, 1'b0, 1'b0);
    cmp("mode_ignored");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
